// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access-width codes, exception
// causes and the controller state enum.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [1:0] CAUSE_LD_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ST_MISALIGN = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT     = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP,
    S_EXC
  } lsu_state_e;

  // 111 never exists; doubleword and unsigned-word loads need a 64-bit datapath
  function automatic logic f3_legal(input logic [2:0] f3, input int xlen);
    return !((f3 == 3'b111) || ((xlen == 32) && ((f3 == F3_D) || (f3 == F3_WU))));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: alignment check, store strobes and replication on
// the request side, lane extraction and sign/zero extension on the response side.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                      req_func3,
  input  logic [2:0]                      req_ea_lo,
  input  logic [XLEN-1:0]                 req_wdata,
  output logic                            misaligned,
  output logic [XLEN/8-1:0]               wstrb,
  output logic [XLEN-1:0]                 wdata,
  input  logic [2:0]                      rsp_func3,
  input  logic [$clog2(XLEN/8)-1:0]       rsp_ea_lo,
  input  logic [XLEN-1:0]                 rdata,
  output logic [XLEN-1:0]                 rdata_ext
);

  localparam int NB  = XLEN / 8;
  localparam int OFF = $clog2(NB);

  logic [OFF-1:0]  wsh;
  logic [XLEN-1:0] rsh;

  assign wsh = req_ea_lo[OFF-1:0];
  assign rsh = rdata >> {rsp_ea_lo, 3'b000};

  always_comb begin
    misaligned = !f3_legal(req_func3, XLEN);
    wstrb      = '0;
    wdata      = req_wdata;
    case (req_func3[1:0])
      2'b00: begin
        wstrb = NB'(1) << wsh;
        wdata = {NB{req_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = misaligned | req_ea_lo[0];
        wstrb      = NB'(2'b11) << wsh;
        wdata      = {(NB/2){req_wdata[15:0]}};
      end
      2'b10: begin
        misaligned = misaligned | (|req_ea_lo[1:0]);
        wstrb      = NB'(4'hF) << wsh;
        wdata      = {(NB/4){req_wdata[31:0]}};
      end
      default: begin
        misaligned = misaligned | (|req_ea_lo);
        wstrb      = '1;
        wdata      = req_wdata;
      end
    endcase
  end

  always_comb begin
    rdata_ext = rsh;
    case (rsp_func3)
      F3_B:    rdata_ext = XLEN'($signed(rsh[7:0]));
      F3_H:    rdata_ext = XLEN'($signed(rsh[15:0]));
      F3_W:    rdata_ext = XLEN'($signed(rsh[31:0]));
      F3_BU:   rdata_ext = XLEN'(rsh[7:0]);
      F3_HU:   rdata_ext = XLEN'(rsh[15:0]);
      F3_WU:   rdata_ext = XLEN'(rsh[31:0]);
      default: rdata_ext = rsh;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store controller between execute and the data-memory port.
//   state  | meaning
//   IDLE   | ready for a new op
//   REQ    | mem_req held until mem_gnt
//   WAIT   | load granted, waiting for mem_rvalid
//   RESP   | one-cycle writeback pulse
//   EXC    | one-cycle exception pulse (misaligned/illegal or timeout)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_load,
  input  logic [2:0]          req_func3,
  input  logic [XLEN-1:0]     req_base,
  input  logic [XLEN-1:0]     req_imm,
  input  logic [XLEN-1:0]     req_wdata,
  input  logic [4:0]          req_rd,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN/8-1:0]   mem_wstrb,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                wb_valid,
  output logic [4:0]          wb_rd,
  output logic [XLEN-1:0]     wb_data,
  output logic                exc_valid,
  output logic [1:0]          exc_cause,
  output logic [ADDR_W-1:0]   exc_addr
);

  localparam int NB  = XLEN / 8;
  localparam int OFF = $clog2(NB);
  localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_e state, state_n;

  logic [XLEN-1:0]   ea_full;
  logic [ADDR_W-1:0] ea;
  logic [ADDR_W-1:0] ea_q;
  logic              load_q;
  logic [2:0]        f3_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   wdata_q;
  logic [NB-1:0]     wstrb_q;
  logic [1:0]        cause_q;
  logic [XLEN-1:0]   wb_q;
  logic [TW-1:0]     tmr;
  logic              tmr_done;

  logic              al_misaligned;
  logic [NB-1:0]     al_wstrb;
  logic [XLEN-1:0]   al_wdata;
  logic [XLEN-1:0]   al_rdata;

  assign ea_full  = req_base + req_imm;
  assign ea       = ADDR_W'(ea_full);
  assign tmr_done = (tmr == '0);

  lsu_align #(.XLEN(XLEN)) u_align (
    .req_func3  (req_func3),
    .req_ea_lo  (ea[2:0]),
    .req_wdata  (req_wdata),
    .misaligned (al_misaligned),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .rsp_func3  (f3_q),
    .rsp_ea_lo  (ea_q[OFF-1:0]),
    .rdata      (mem_rdata),
    .rdata_ext  (al_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Grant and read data take priority over an expiring timer
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (req_valid) state_n = al_misaligned ? S_EXC : S_REQ;
      S_REQ: begin
        if (mem_gnt) begin
          if (!load_q)         state_n = S_IDLE;
          else if (mem_rvalid) state_n = S_RESP;
          else                 state_n = S_WAIT;
        end else if (tmr_done) begin
          state_n = S_EXC;
        end
      end
      S_WAIT: begin
        if (mem_rvalid)    state_n = S_RESP;
        else if (tmr_done) state_n = S_EXC;
      end
      S_RESP:  state_n = S_IDLE;
      S_EXC:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ea_q    <= '0;
      load_q  <= 1'b0;
      f3_q    <= '0;
      rd_q    <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cause_q <= '0;
      wb_q    <= '0;
      tmr     <= '0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        ea_q    <= ea;
        load_q  <= req_load;
        f3_q    <= req_func3;
        rd_q    <= req_rd;
        wdata_q <= al_wdata;
        wstrb_q <= al_wstrb;
        cause_q <= req_load ? CAUSE_LD_MISALIGN : CAUSE_ST_MISALIGN;
        tmr     <= TW'(TIMEOUT - 1);
      end
      if (state == S_REQ || state == S_WAIT) begin
        if (state_n == S_WAIT)  tmr <= TW'(TIMEOUT - 1);
        else if (!tmr_done)     tmr <= tmr - 1'b1;
        if (state_n == S_EXC)   cause_q <= CAUSE_TIMEOUT;
        if (state_n == S_RESP)  wb_q <= al_rdata;
      end
    end
  end

  always_comb begin
    req_ready = (state == S_IDLE);
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wstrb = '0;
    mem_wdata = '0;
    wb_valid  = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;
    exc_valid = 1'b0;
    exc_cause = '0;
    exc_addr  = '0;
    case (state)
      S_REQ: begin
        mem_req   = 1'b1;
        mem_we    = !load_q;
        mem_addr  = {ea_q[ADDR_W-1:OFF], {OFF{1'b0}}};
        mem_wstrb = wstrb_q;
        mem_wdata = wdata_q;
      end
      S_RESP: begin
        wb_valid = 1'b1;
        wb_rd    = rd_q;
        wb_data  = wb_q;
      end
      S_EXC: begin
        exc_valid = 1'b1;
        exc_cause = cause_q;
        exc_addr  = ea_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (XLEN=32, TIMEOUT=4): a vector table of
// single ops with zero-wait memory, plus hand-written multi-cycle sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_load;
  logic [2:0]  req_func3;
  logic [31:0] req_base, req_imm, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_valid;
  logic [1:0]  exc_cause;
  logic [31:0] exc_addr;

  load_store_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
    .req_func3(req_func3), .req_base(req_base), .req_imm(req_imm),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [2:0]  f3;
    logic [31:0] base;
    logic [31:0] imm;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exc;
    logic [1:0]  cause;
    logic [31:0] ea;
    logic [31:0] maddr;
    logic [3:0]  strb;
    logic [31:0] wd;
    logic [31:0] wbd;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_req(input logic ld, input logic [2:0] f3, input logic [31:0] base,
                           input logic [31:0] imm, input logic [31:0] wd, input logic [4:0] rd);
    req_valid = 1'b1;
    req_load  = ld;
    req_func3 = f3;
    req_base  = base;
    req_imm   = imm;
    req_wdata = wd;
    req_rd    = rd;
  endtask

  vec_t vecs[16];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : main
    int   req_cycles;
    logic got;
    logic stray;

    vecs[0]  = '{1'b1, 3'b000, 32'h0000_1000, 32'h0000_0003, 32'h0,           32'h80FF_FF00, 1'b0, 2'b00, 32'h1003, 32'h1000, 4'b0000, 32'h0,           32'hFFFF_FF80};
    vecs[1]  = '{1'b1, 3'b101, 32'h0000_2000, 32'h0000_0002, 32'h0,           32'hBEEF_1234, 1'b0, 2'b00, 32'h2002, 32'h2000, 4'b0000, 32'h0,           32'h0000_BEEF};
    vecs[2]  = '{1'b0, 3'b000, 32'h0000_3005, 32'hFFFF_FFFC, 32'h1234_56AB, 32'h0,         1'b0, 2'b00, 32'h3001, 32'h3000, 4'b0010, 32'hABAB_ABAB, 32'h0};
    vecs[3]  = '{1'b1, 3'b010, 32'h0000_4000, 32'h0000_0002, 32'h0,           32'h0,         1'b1, 2'b01, 32'h4002, 32'h0,    4'b0000, 32'h0,           32'h0};
    vecs[4]  = '{1'b0, 3'b001, 32'h0000_4000, 32'h0000_0001, 32'h5555_5555, 32'h0,         1'b1, 2'b10, 32'h4001, 32'h0,    4'b0000, 32'h0,           32'h0};
    vecs[5]  = '{1'b1, 3'b001, 32'h0000_5000, 32'h0000_0002, 32'h0,           32'h8001_7FFF, 1'b0, 2'b00, 32'h5002, 32'h5000, 4'b0000, 32'h0,           32'hFFFF_8001};
    vecs[6]  = '{1'b1, 3'b010, 32'h0000_6000, 32'h0000_0000, 32'h0,           32'hDEAD_BEEF, 1'b0, 2'b00, 32'h6000, 32'h6000, 4'b0000, 32'h0,           32'hDEAD_BEEF};
    vecs[7]  = '{1'b0, 3'b010, 32'h0000_7000, 32'h0000_0004, 32'hCAFE_F00D, 32'h0,         1'b0, 2'b00, 32'h7004, 32'h7004, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[8]  = '{1'b0, 3'b001, 32'h0000_8000, 32'h0000_0002, 32'h0000_BEEF, 32'h0,         1'b0, 2'b00, 32'h8002, 32'h8000, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    vecs[9]  = '{1'b1, 3'b011, 32'h0000_9000, 32'h0000_0000, 32'h0,           32'h0,         1'b1, 2'b01, 32'h9000, 32'h0,    4'b0000, 32'h0,           32'h0};
    vecs[10] = '{1'b0, 3'b111, 32'h0000_A000, 32'h0000_0000, 32'h0,           32'h0,         1'b1, 2'b10, 32'hA000, 32'h0,    4'b0000, 32'h0,           32'h0};
    vecs[11] = '{1'b1, 3'b100, 32'h0000_B000, 32'h0000_0001, 32'h0,           32'h1234_80CD, 1'b0, 2'b00, 32'hB001, 32'hB000, 4'b0000, 32'h0,           32'h0000_0080};
    vecs[12] = '{1'b1, 3'b110, 32'h0000_C000, 32'h0000_0000, 32'h0,           32'h0,         1'b1, 2'b01, 32'hC000, 32'h0,    4'b0000, 32'h0,           32'h0};
    vecs[13] = '{1'b1, 3'b100, 32'hFFFF_FFFF, 32'h0000_1001, 32'h0,           32'h0000_00F0, 1'b0, 2'b00, 32'h1000, 32'h1000, 4'b0000, 32'h0,           32'h0000_00F0};
    vecs[14] = '{1'b1, 3'b001, 32'h0000_5000, 32'h0000_0003, 32'h0,           32'h0,         1'b1, 2'b01, 32'h5003, 32'h0,    4'b0000, 32'h0,           32'h0};
    vecs[15] = '{1'b0, 3'b000, 32'h0000_D000, 32'h0000_0003, 32'h0000_00FF, 32'h0,         1'b0, 2'b00, 32'hD003, 32'hD000, 4'b1000, 32'hFFFF_FFFF, 32'h0};

    rst = 1'b1;
    req_valid = 1'b0; req_load = 1'b0; req_func3 = '0; req_base = '0;
    req_imm = '0; req_wdata = '0; req_rd = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    tick;
    tick;
    chk("reset req_ready", req_ready, 1'b1);
    chk("reset mem_req", mem_req, 1'b0);
    chk("reset wb_valid", wb_valid, 1'b0);
    chk("reset exc_valid", exc_valid, 1'b0);
    rst = 1'b0;
    tick;

    for (int i = 0; i < 16; i++) begin
      drive_req(vecs[i].ld, vecs[i].f3, vecs[i].base, vecs[i].imm, vecs[i].wdata, 5'(i + 1));
      chk($sformatf("v%0d req_ready", i), req_ready, 1'b1);
      tick;
      req_valid = 1'b0;
      if (vecs[i].exc) begin
        chk($sformatf("v%0d exc_valid", i), exc_valid, 1'b1);
        chk($sformatf("v%0d exc_cause", i), exc_cause, vecs[i].cause);
        chk($sformatf("v%0d exc_addr", i), exc_addr, vecs[i].ea);
        chk($sformatf("v%0d mem_req", i), mem_req, 1'b0);
        tick;
        chk($sformatf("v%0d ready after exc", i), req_ready, 1'b1);
        chk($sformatf("v%0d exc pulse end", i), exc_valid, 1'b0);
      end else begin
        chk($sformatf("v%0d mem_req", i), mem_req, 1'b1);
        chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].maddr);
        chk($sformatf("v%0d mem_we", i), mem_we, !vecs[i].ld);
        if (!vecs[i].ld) begin
          chk($sformatf("v%0d mem_wstrb", i), mem_wstrb, vecs[i].strb);
          chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].wd);
        end
        mem_gnt    = 1'b1;
        mem_rvalid = vecs[i].ld;
        mem_rdata  = vecs[i].rdata;
        tick;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        if (vecs[i].ld) begin
          chk($sformatf("v%0d wb_valid", i), wb_valid, 1'b1);
          chk($sformatf("v%0d wb_data", i), wb_data, vecs[i].wbd);
          chk($sformatf("v%0d wb_rd", i), wb_rd, 5'(i + 1));
          tick;
          chk($sformatf("v%0d ready after load", i), req_ready, 1'b1);
        end else begin
          chk($sformatf("v%0d store no wb", i), wb_valid, 1'b0);
          chk($sformatf("v%0d ready after store", i), req_ready, 1'b1);
        end
      end
    end

    // LHU with read data three cycles after the grant
    drive_req(1'b1, 3'b101, 32'h2000, 32'h2, 32'h0, 5'd17);
    tick;
    req_valid = 1'b0;
    chk("slow lhu mem_req", mem_req, 1'b1);
    mem_gnt = 1'b1;
    tick;
    mem_gnt = 1'b0;
    chk("slow lhu req dropped", mem_req, 1'b0);
    chk("slow lhu not ready", req_ready, 1'b0);
    tick;
    chk("slow lhu no early wb", wb_valid, 1'b0);
    tick;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBEEF_1234;
    tick;
    mem_rvalid = 1'b0;
    chk("slow lhu wb_valid", wb_valid, 1'b1);
    chk("slow lhu wb_data", wb_data, 32'h0000_BEEF);
    chk("slow lhu wb_rd", wb_rd, 5'd17);
    tick;

    // Load never granted: timeout after four request cycles
    drive_req(1'b1, 3'b010, 32'h5000, 32'h0, 32'h0, 5'd3);
    tick;
    req_valid  = 1'b0;
    req_cycles = 0;
    got        = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      if (mem_req) req_cycles++;
      if (exc_valid) begin
        got = 1'b1;
        chk("timeout cause", exc_cause, 2'b11);
        chk("timeout addr", exc_addr, 32'h5000);
        chk("timeout mem_req low", mem_req, 1'b0);
      end else begin
        tick;
      end
    end
    chk("timeout exc seen", got, 1'b1);
    chk("timeout req cycles", req_cycles, 4);
    tick;
    chk("timeout ready", req_ready, 1'b1);

    // Store granted on the expiry cycle: grant wins, no exception
    drive_req(1'b0, 3'b010, 32'h6000, 32'h0, 32'h11, 5'd0);
    tick;
    req_valid = 1'b0;
    tick;
    tick;
    tick;
    chk("expiry mem_req", mem_req, 1'b1);
    mem_gnt = 1'b1;
    tick;
    mem_gnt = 1'b0;
    chk("expiry no exc", exc_valid, 1'b0);
    chk("expiry ready", req_ready, 1'b1);
    tick;

    // Reset while waiting for read data aborts the load
    drive_req(1'b1, 3'b010, 32'h7000, 32'h0, 32'h0, 5'd9);
    tick;
    req_valid = 1'b0;
    mem_gnt   = 1'b1;
    tick;
    mem_gnt = 1'b0;
    chk("rst-wait in wait", req_ready, 1'b0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst-wait ready", req_ready, 1'b1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1357_9BDF;
    tick;
    mem_rvalid = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (wb_valid || exc_valid || mem_req) stray = 1'b1;
      tick;
    end
    chk("rst-wait no stray output", stray, 1'b0);
    chk("rst-wait still ready", req_ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
